// File: rtl/conv_pkg.sv
// Shared types and helpers for the parametrised convolution engine.
package conv_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_MAC  = 3'd1,
      ST_SUM  = 3'd2,
      ST_OUT  = 3'd3,
      ST_DONE = 3'd4
   } state_e;

   localparam logic WR_SEL_IMG = 1'b0;
   localparam logic WR_SEL_KER = 1'b1;

   // Index width for n items, never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/conv_lane.sv
// One multiply-accumulate lane; accumulates full-width products modulo 2^ACCW.
module conv_lane #(
   parameter int DW   = 8,
   parameter int ACCW = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clear,
   input  logic            en,
   input  logic [DW-1:0]   din,
   input  logic [DW-1:0]   win,
   output logic [ACCW-1:0] acc
);

   localparam int SW = (2 * DW > ACCW) ? 2 * DW : ACCW;

   logic [ACCW-1:0] acc_q;
   logic [ACCW-1:0] acc_d;

   always_comb begin
      acc_d = acc_q;
      if (clear) begin
         acc_d = '0;
      end else if (en) begin
         acc_d = ACCW'(SW'(acc_q) + SW'(din) * SW'(win));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc = acc_q;

endmodule

// File: rtl/conv_sa_engine.sv
// Valid-convolution engine: register-held image and kernel, K row-parallel MAC lanes,
// raster-order results over a valid/ready handshake with a run-time cycle counter.
module conv_sa_engine
   import conv_pkg::*;
#(
   parameter int DW   = 8,
   parameter int ACCW = 8,
   parameter int IMG  = 4,
   parameter int K    = 3,
   parameter int AW   = idx_w(IMG * IMG),
   localparam int OW  = idx_w(IMG - K + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wr_en,
   input  logic            wr_sel,
   input  logic [AW-1:0]   wr_addr,
   input  logic [DW-1:0]   wr_data,
   input  logic            start,
   output logic            busy,
   output logic            done,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [ACCW-1:0] out_data,
   output logic [OW-1:0]   out_row,
   output logic [OW-1:0]   out_col,
   output logic [31:0]     cycle_count
);

   localparam int NIMG = IMG * IMG;
   localparam int NKER = K * K;
   localparam int IAW  = idx_w(NIMG);
   localparam int KAW  = idx_w(NKER);
   localparam int KW   = idx_w(K);
   localparam logic [OW-1:0] LAST = OW'(IMG - K);
   localparam logic [KW-1:0] JLAST = KW'(K - 1);

   state_e          state_q, state_d;
   logic [OW-1:0]   r_q, r_d;
   logic [OW-1:0]   c_q, c_d;
   logic [KW-1:0]   j_q, j_d;
   logic [DW-1:0]   img_q [NIMG];
   logic [DW-1:0]   img_d [NIMG];
   logic [DW-1:0]   ker_q [NKER];
   logic [DW-1:0]   ker_d [NKER];
   logic            out_valid_q, out_valid_d;
   logic [ACCW-1:0] out_data_q, out_data_d;
   logic [OW-1:0]   out_row_q, out_row_d;
   logic [OW-1:0]   out_col_q, out_col_d;
   logic [31:0]     cyc_q, cyc_d;

   logic            lane_clear;
   logic            lane_en;
   logic [DW-1:0]   lane_din [K];
   logic [DW-1:0]   lane_win [K];
   logic [ACCW-1:0] lane_acc [K];
   logic [ACCW-1:0] acc_sum;
   logic            idle_like;

   assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);

   // Lane i sees image row r+i and kernel row i at tap column j.
   always_comb begin
      for (int i = 0; i < K; i++) begin
         lane_din[i] = img_q[IAW'((int'(r_q) + i) * IMG + int'(c_q) + int'(j_q))];
         lane_win[i] = ker_q[KAW'(i * K + int'(j_q))];
      end
      acc_sum = '0;
      for (int i = 0; i < K; i++) begin
         acc_sum = acc_sum + lane_acc[i];
      end
   end

   for (genvar gi = 0; gi < K; gi++) begin : g_lane
      conv_lane #(
         .DW   (DW),
         .ACCW (ACCW)
      ) u_lane (
         .clk   (clk),
         .rst   (rst),
         .clear (lane_clear),
         .en    (lane_en),
         .din   (lane_din[gi]),
         .win   (lane_win[gi]),
         .acc   (lane_acc[gi])
      );
   end

   always_comb begin
      state_d     = state_q;
      r_d         = r_q;
      c_d         = c_q;
      j_d         = j_q;
      img_d       = img_q;
      ker_d       = ker_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_row_d   = out_row_q;
      out_col_d   = out_col_q;
      cyc_d       = cyc_q;
      lane_clear  = 1'b0;
      lane_en     = 1'b0;

      // Writes land in the same edge as a start, so the run sees the new value.
      if (idle_like && wr_en) begin
         if (wr_sel == WR_SEL_IMG && int'(wr_addr) < NIMG) begin
            img_d[IAW'(wr_addr)] = wr_data;
         end else if (wr_sel == WR_SEL_KER && int'(wr_addr) < NKER) begin
            ker_d[KAW'(wr_addr)] = wr_data;
         end
      end

      if (state_q == ST_MAC || state_q == ST_SUM || state_q == ST_OUT) begin
         if (cyc_q != 32'hFFFF_FFFF) begin
            cyc_d = cyc_q + 32'd1;
         end
      end

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d    = ST_MAC;
               r_d        = '0;
               c_d        = '0;
               j_d        = '0;
               cyc_d      = '0;
               lane_clear = 1'b1;
            end
         end
         ST_MAC: begin
            lane_en = 1'b1;
            if (j_q == JLAST) begin
               j_d     = '0;
               state_d = ST_SUM;
            end else begin
               j_d = j_q + KW'(1);
            end
         end
         ST_SUM: begin
            out_data_d  = acc_sum;
            out_row_d   = r_q;
            out_col_d   = c_q;
            out_valid_d = 1'b1;
            state_d     = ST_OUT;
         end
         ST_OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               lane_clear  = 1'b1;
               if (r_q == LAST && c_q == LAST) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_MAC;
                  if (c_q == LAST) begin
                     c_d = '0;
                     r_d = r_q + OW'(1);
                  end else begin
                     c_d = c_q + OW'(1);
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         r_q         <= '0;
         c_q         <= '0;
         j_q         <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_row_q   <= '0;
         out_col_q   <= '0;
         cyc_q       <= '0;
         for (int i = 0; i < NIMG; i++) img_q[i] <= '0;
         for (int i = 0; i < NKER; i++) ker_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         r_q         <= r_d;
         c_q         <= c_d;
         j_q         <= j_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_row_q   <= out_row_d;
         out_col_q   <= out_col_d;
         cyc_q       <= cyc_d;
         img_q       <= img_d;
         ker_q       <= ker_d;
      end
   end

   assign busy        = !idle_like;
   assign done        = (state_q == ST_DONE);
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign out_row     = out_row_q;
   assign out_col     = out_col_q;
   assign cycle_count = cyc_q;

endmodule

// File: tb/tb_conv_sa_engine.sv
// Scoreboard bench for conv_sa_engine: default 4x4/3x3 instance plus a 3x3/3x3 instance.
module tb_conv_sa_engine;

   typedef struct {
      logic [31:0] data;
      logic [31:0] row;
      logic [31:0] col;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // default instance
   logic       wr_en, wr_sel, start, out_ready;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;
   logic       busy, done, out_valid;
   logic [7:0] out_data;
   logic [0:0] out_row, out_col;
   logic [31:0] cycle_count;

   // IMG=K=3 instance
   logic       wr_en2, wr_sel2, start2, out_ready2;
   logic [3:0] wr_addr2;
   logic [7:0] wr_data2;
   logic       busy2, done2, out_valid2;
   logic [7:0] out_data2;
   logic [0:0] out_row2, out_col2;
   logic [31:0] cycle_count2;

   int checks = 0;
   int errors = 0;
   exp_t q1[$];
   exp_t q2[$];

   conv_sa_engine #(.DW(8), .ACCW(8), .IMG(4), .K(3)) u_dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
      .wr_data(wr_data), .start(start), .busy(busy), .done(done),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_row(out_row), .out_col(out_col), .cycle_count(cycle_count)
   );

   conv_sa_engine #(.DW(8), .ACCW(8), .IMG(3), .K(3)) u_dut2 (
      .clk(clk), .rst(rst), .wr_en(wr_en2), .wr_sel(wr_sel2), .wr_addr(wr_addr2),
      .wr_data(wr_data2), .start(start2), .busy(busy2), .done(done2),
      .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
      .out_row(out_row2), .out_col(out_col2), .cycle_count(cycle_count2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push1(input int d, input int r, input int c);
      exp_t e;
      e.data = d; e.row = r; e.col = c;
      q1.push_back(e);
   endtask

   task automatic push_base();
      push1(45, 0, 0); push1(54, 0, 1); push1(81, 1, 0); push1(90, 1, 1);
   endtask

   // Monitors: pop and compare on every accepted output.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && out_valid && out_ready) begin
         if (q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL u1_unexpected_output got=%0d expected=none", out_data);
         end else begin
            e = q1.pop_front();
            chk("u1_data", 32'(out_data), e.data);
            chk("u1_row", 32'(out_row), e.row);
            chk("u1_col", 32'(out_col), e.col);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!rst && out_valid2 && out_ready2) begin
         if (q2.size() == 0) begin
            checks++; errors++;
            $display("FAIL u2_unexpected_output got=%0d expected=none", out_data2);
         end else begin
            e = q2.pop_front();
            chk("u2_data", 32'(out_data2), e.data);
            chk("u2_row", 32'(out_row2), e.row);
            chk("u2_col", 32'(out_col2), e.col);
         end
      end
   end

   task automatic write1(input logic sel, input int addr, input int data);
      wr_en = 1'b1; wr_sel = sel; wr_addr = 4'(addr); wr_data = 8'(data);
      tick();
      wr_en = 1'b0;
   endtask

   task automatic wait_done1(input string name, input int exp_cycles);
      int n = 0;
      while (!done && n < 300) begin
         tick();
         n++;
      end
      chk({name, "_done"}, 32'(done), 32'd1);
      chk({name, "_cycles"}, cycle_count, 32'(exp_cycles));
      chk({name, "_drained"}, 32'(q1.size()), 32'd0);
   endtask

   task automatic run1(input string name, input int exp_cycles);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done1(name, exp_cycles);
   endtask

   initial begin
      int n;
      rst = 1'b1;
      wr_en = 0; wr_sel = 0; wr_addr = '0; wr_data = '0; start = 0; out_ready = 1;
      wr_en2 = 0; wr_sel2 = 0; wr_addr2 = '0; wr_data2 = '0; start2 = 0; out_ready2 = 1;
      tick(); tick();
      rst = 1'b0;
      tick();

      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_cycles", cycle_count, 0);
      chk("rst_data", 32'(out_data), 0);

      // image 0..15, kernel all ones
      for (int i = 0; i < 16; i++) write1(1'b0, i, i);
      for (int i = 0; i < 9; i++) write1(1'b1, i, 1);
      push_base();
      run1("basic", 20);

      // first result stalled for three cycles
      push_base();
      out_ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!out_valid && n < 50) begin
         tick();
         n++;
      end
      for (int s = 0; s < 3; s++) begin
         chk("stall_valid", 32'(out_valid), 1);
         chk("stall_data", 32'(out_data), 45);
         if (s < 2) tick();
      end
      tick();
      out_ready = 1'b1;
      wait_done1("stall", 23);

      // kernel write and second start while busy are ignored
      push_base();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 4'd0; wr_data = 8'd7; start = 1'b1;
      tick();
      wr_en = 1'b0; start = 1'b0;
      chk("busy_mid_run", 32'(busy), 1);
      wait_done1("ignore", 20);
      push_base();
      run1("rerun", 20);

      // 255 * 255 mod 256 = 1 per tap, nine taps
      for (int i = 0; i < 16; i++) write1(1'b0, i, 255);
      for (int i = 0; i < 9; i++) write1(1'b1, i, 255);
      push1(9, 0, 0); push1(9, 0, 1); push1(9, 1, 0); push1(9, 1, 1);
      run1("wrap", 20);

      // reset in second MAC cycle aborts and clears storage
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_valid", 32'(out_valid), 0);
      chk("abort_cycles", cycle_count, 0);
      chk("abort_done", 32'(done), 0);
      push1(0, 0, 0); push1(0, 0, 1); push1(0, 1, 0); push1(0, 1, 1);
      run1("zero", 20);

      // single-output instance
      for (int i = 0; i < 9; i++) begin
         wr_en2 = 1'b1; wr_sel2 = 1'b0; wr_addr2 = 4'(i); wr_data2 = 8'(i + 1);
         tick();
      end
      for (int i = 0; i < 9; i++) begin
         wr_en2 = 1'b1; wr_sel2 = 1'b1; wr_addr2 = 4'(i); wr_data2 = 8'(i + 1);
         tick();
      end
      wr_en2 = 1'b0;
      begin
         exp_t e;
         e.data = 29; e.row = 0; e.col = 0;
         q2.push_back(e);
      end
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      n = 0;
      while (!done2 && n < 100) begin
         tick();
         n++;
      end
      chk("single_done", 32'(done2), 1);
      chk("single_cycles", cycle_count2, 5);
      chk("single_drained", 32'(q2.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
